// File: rtl/pt_pkg.sv
// Shared helpers for the Pan-Tompkins stages: clog2, accumulator sizing and
// channel-index width.
package pt_pkg;

  function automatic int pt_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Peak gain of the squared-comb kernel is D^2 <= 2^(2*clog2(D)); two extra
  // bits cover the 2*y[n-1] intermediate.
  function automatic int pt_acc_width(input int data_width, input int delay);
    return data_width + 2 * pt_clog2(delay) + 2;
  endfunction

  function automatic int pt_ch_width(input int num_ch);
    return (num_ch > 1) ? pt_clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pt_hist_ram.sv
// Per-channel history store: a 2*D-deep circular x buffer with its own write
// pointer, plus the last two y values. Reads are combinational for channel ch.
module pt_hist_ram
  import pt_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int DELAY      = 6,
  parameter int ACC_WIDTH  = 19,
  parameter int CH_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [CH_WIDTH-1:0]   ch,
  input  logic [DATA_WIDTH-1:0] x_new,
  input  logic [ACC_WIDTH-1:0]  y_new,
  output logic [DATA_WIDTH-1:0] x_d,
  output logic [DATA_WIDTH-1:0] x_2d,
  output logic [ACC_WIDTH-1:0]  y_1,
  output logic [ACC_WIDTH-1:0]  y_2
);
  localparam int DEPTH = 2 * DELAY;
  localparam int PW    = pt_clog2(DEPTH);
  localparam int NSLOT = 2 ** CH_WIDTH;

  logic [DATA_WIDTH-1:0] xh [NSLOT][DEPTH];
  logic [ACC_WIDTH-1:0]  y1h [NSLOT];
  logic [ACC_WIDTH-1:0]  y2h [NSLOT];
  logic [PW-1:0]         wptr [NSLOT];
  logic [PW-1:0]         ptr, ptr_mid, ptr_next;

  // The slot about to be overwritten holds x[n-2D]; the slot D ahead holds x[n-D].
  assign ptr = wptr[ch];

  always_comb begin
    ptr_mid = ptr + PW'(DELAY);
    if (ptr >= PW'(DELAY)) ptr_mid = ptr - PW'(DELAY);
  end

  assign ptr_next = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

  assign x_2d = xh[ch][ptr];
  assign x_d  = xh[ch][ptr_mid];
  assign y_1  = y1h[ch];
  assign y_2  = y2h[ch];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int c = 0; c < NSLOT; c++) begin
        for (int k = 0; k < DEPTH; k++) xh[c][k] <= '0;
        y1h[c]  <= '0;
        y2h[c]  <= '0;
        wptr[c] <= '0;
      end
    end else if (wr_en) begin
      xh[ch][ptr] <= x_new;
      wptr[ch]    <= ptr_next;
      y2h[ch]     <= y1h[ch];
      y1h[ch]     <= y_new;
    end
  end

endmodule

// File: rtl/pt_lowpass_filter.sv
// Multichannel Pan-Tompkins low-pass: y = 2y1 - y2 + x - 2x[n-D] + x[n-2D].
// Define PT_LPF_SAT_EN to clamp the shifted output instead of wrapping it.
module pt_lowpass_filter
  import pt_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int DELAY      = 6,
  parameter int NUM_CH     = 1,
  parameter int GAIN_SHIFT = 0,
  parameter int OUT_WIDTH  = DATA_WIDTH + 2 * pt_clog2(DELAY)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [pt_ch_width(NUM_CH)-1:0] in_ch,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [pt_ch_width(NUM_CH)-1:0] out_ch,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           sat_flag,
  output logic                           ch_err
);
  localparam int CW = pt_ch_width(NUM_CH);
  localparam int AW = pt_acc_width(DATA_WIDTH, DELAY);
  localparam int EW = ((AW > OUT_WIDTH) ? AW : OUT_WIDTH) + 1;
  localparam logic [CW:0] NUM_CH_W = (CW + 1)'(NUM_CH);

  logic                  accept, ch_ok, wr_en;
  logic [DATA_WIDTH-1:0] x_d, x_2d;
  logic [AW-1:0]         y_1, y_2;
  logic signed [AW-1:0]  xn_e, xd_e, x2d_e, y_new, y_shift;
  logic signed [EW-1:0]  y_ext;
  logic [OUT_WIDTH-1:0]  res;
  logic                  res_sat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign ch_ok    = {1'b0, in_ch} < NUM_CH_W;
  assign wr_en    = accept && ch_ok && !clr;

  pt_hist_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DELAY     (DELAY),
    .ACC_WIDTH (AW),
    .CH_WIDTH  (CW)
  ) u_hist (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .wr_en(wr_en),
    .ch   (in_ch),
    .x_new(in_data),
    .y_new(y_new),
    .x_d  (x_d),
    .x_2d (x_2d),
    .y_1  (y_1),
    .y_2  (y_2)
  );

  // Intermediates may wrap in AW bits; the final sum is exact by construction.
  assign xn_e    = AW'($signed(in_data));
  assign xd_e    = AW'($signed(x_d));
  assign x2d_e   = AW'($signed(x_2d));
  assign y_new   = ($signed(y_1) <<< 1) - $signed(y_2) + xn_e - (xd_e <<< 1) + x2d_e;
  assign y_shift = y_new >>> GAIN_SHIFT;
  assign y_ext   = EW'(y_shift);

`ifdef PT_LPF_SAT_EN
  localparam logic signed [EW-1:0] OUT_MAX = {{(EW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [EW-1:0] OUT_MIN = {{(EW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  always_comb begin
    res     = y_ext[OUT_WIDTH-1:0];
    res_sat = 1'b0;
    if (y_ext > OUT_MAX) begin
      res     = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      res_sat = 1'b1;
    end else if (y_ext < OUT_MIN) begin
      res     = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      res_sat = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^y_ext[EW-1:OUT_WIDTH];
  assign res       = y_ext[OUT_WIDTH-1:0];
  assign res_sat   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sat_flag  <= 1'b0;
      ch_err    <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      ch_err    <= 1'b0;
    end else begin
      ch_err <= accept && !ch_ok;
      if (accept && ch_ok) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_ch    <= in_ch;
        sat_flag  <= res_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pt_lowpass_filter.sv
// Bench for pt_lowpass_filter: a default instance and a 2-channel, 12-bit,
// shift-by-1 instance, checked against a direct triangle-kernel convolution.
module tb_pt_lowpass_filter;

  localparam int A_OW = 17;
  localparam int B_OW = 12;
  localparam int B_GS = 1;

  typedef struct {
    int     ch;
    longint d;
    bit     s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  logic            a_in_valid = 1'b0, a_in_ready, a_in_ch = 1'b0;
  logic [10:0]     a_in_data = '0;
  logic            a_out_valid, a_out_ready = 1'b1, a_out_ch, a_sat, a_ch_err;
  logic [A_OW-1:0] a_out_data;

  logic            b_in_valid = 1'b0, b_in_ready, b_in_ch = 1'b0;
  logic [10:0]     b_in_data = '0;
  logic            b_out_valid, b_out_ready = 1'b1, b_out_ch, b_sat, b_ch_err;
  logic [B_OW-1:0] b_out_data;

  int checks = 0;
  int errors = 0;

  exp_t   a_exp[$], b_exp[$];
  exp_t   a_e, b_e;
  longint a_hist[2][$];
  longint b_hist[2][$];
  longint a_got[$], b_got[$];
  int     a_got_ch[$], b_got_ch[$];
  bit     b_got_s[$];
  bit     a_cherr_exp = 0, b_cherr_exp = 0;
  bit     a_hold = 0, b_hold = 0;
  logic [A_OW-1:0] a_hold_d;
  logic [B_OW-1:0] b_hold_d;
  logic            a_hold_ch, b_hold_ch;
  int tri_ref[16] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 0, 0, 0, 0};

  pt_lowpass_filter u_a (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ch(a_in_ch), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch),
    .out_data(a_out_data), .sat_flag(a_sat), .ch_err(a_ch_err)
  );

  pt_lowpass_filter #(.NUM_CH(2), .GAIN_SHIFT(B_GS), .OUT_WIDTH(B_OW)) u_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ch(b_in_ch), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch),
    .out_data(b_out_data), .sat_flag(b_sat), .ch_err(b_ch_err)
  );

  always #5 clk = ~clk;

  // Reference: y[n] is the input convolved with the triangle 1..D..1.
  function automatic longint tri_resp(input longint h[$], input int d);
    longint s = 0;
    for (int k = 0; k < 2 * d - 1 && k < h.size(); k++)
      s += longint'((k < d) ? (k + 1) : (2 * d - 1 - k)) * h[k];
    return s;
  endfunction

  function automatic exp_t predict(input longint h[$], input int ch, input int gs, input int ow);
    exp_t   e;
    longint y, lim, v;
    y   = tri_resp(h, 6) >>> gs;
    lim = longint'(1) <<< (ow - 1);
    e.ch = ch;
    e.s  = 0;
`ifdef PT_LPF_SAT_EN
    if (y > lim - 1) begin v = lim - 1; e.s = 1; end
    else if (y < -lim) begin v = -lim; e.s = 1; end
    else v = y;
`else
    v = y & (2 * lim - 1);
    if (v >= lim) v -= 2 * lim;
`endif
    e.d = v;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      a_exp.delete(); a_hist[0].delete(); a_hist[1].delete();
      a_cherr_exp = 0; a_hold = 0;
    end else begin
      checks++;
      if (a_ch_err !== a_cherr_exp) begin
        errors++; $display("FAIL a_ch_err got %b exp %b at %0t", a_ch_err, a_cherr_exp, $time);
      end
      checks++;
      if (a_in_ready !== (!a_out_valid || a_out_ready)) begin
        errors++; $display("FAIL a_in_ready got %b exp %b at %0t", a_in_ready, !a_out_valid || a_out_ready, $time);
      end
      if (a_hold) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== a_hold_d || a_out_ch !== a_hold_ch) begin
          errors++; $display("FAIL a_hold got %b/%0d exp 1/%0d at %0t", a_out_valid, a_out_data, a_hold_d, $time);
        end
      end
      a_hold = a_out_valid && !a_out_ready && !clr;
      a_hold_d = a_out_data; a_hold_ch = a_out_ch;
      if (a_out_valid && a_out_ready) begin
        a_got.push_back(longint'($signed(a_out_data)));
        a_got_ch.push_back(int'(a_out_ch));
        checks++;
        if (a_exp.size() == 0) begin
          errors++; $display("FAIL a_unexpected_out got %0d exp none at %0t", $signed(a_out_data), $time);
        end else begin
          a_e = a_exp.pop_front();
          if (longint'($signed(a_out_data)) !== a_e.d || int'(a_out_ch) != a_e.ch || a_sat !== a_e.s) begin
            errors++;
            $display("FAIL a_out got %0d ch%0d s%b exp %0d ch%0d s%b at %0t",
                     $signed(a_out_data), a_out_ch, a_sat, a_e.d, a_e.ch, a_e.s, $time);
          end
        end
      end
      a_cherr_exp = 0;
      if (clr) begin
        a_exp.delete(); a_hist[0].delete(); a_hist[1].delete();
      end else if (a_in_valid && a_in_ready) begin
        if (int'(a_in_ch) < 1) begin
          a_hist[a_in_ch].push_front(longint'($signed(a_in_data)));
          if (a_hist[a_in_ch].size() > 12) void'(a_hist[a_in_ch].pop_back());
          a_exp.push_back(predict(a_hist[a_in_ch], int'(a_in_ch), 0, A_OW));
        end else begin
          a_cherr_exp = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_exp.delete(); b_hist[0].delete(); b_hist[1].delete();
      b_cherr_exp = 0; b_hold = 0;
    end else begin
      checks++;
      if (b_ch_err !== b_cherr_exp) begin
        errors++; $display("FAIL b_ch_err got %b exp %b at %0t", b_ch_err, b_cherr_exp, $time);
      end
      checks++;
      if (b_in_ready !== (!b_out_valid || b_out_ready)) begin
        errors++; $display("FAIL b_in_ready got %b exp %b at %0t", b_in_ready, !b_out_valid || b_out_ready, $time);
      end
      if (b_hold) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== b_hold_d || b_out_ch !== b_hold_ch) begin
          errors++; $display("FAIL b_hold got %b/%0d exp 1/%0d at %0t", b_out_valid, b_out_data, b_hold_d, $time);
        end
      end
      b_hold = b_out_valid && !b_out_ready && !clr;
      b_hold_d = b_out_data; b_hold_ch = b_out_ch;
      if (b_out_valid && b_out_ready) begin
        b_got.push_back(longint'($signed(b_out_data)));
        b_got_ch.push_back(int'(b_out_ch));
        b_got_s.push_back(b_sat);
        checks++;
        if (b_exp.size() == 0) begin
          errors++; $display("FAIL b_unexpected_out got %0d exp none at %0t", $signed(b_out_data), $time);
        end else begin
          b_e = b_exp.pop_front();
          if (longint'($signed(b_out_data)) !== b_e.d || int'(b_out_ch) != b_e.ch || b_sat !== b_e.s) begin
            errors++;
            $display("FAIL b_out got %0d ch%0d s%b exp %0d ch%0d s%b at %0t",
                     $signed(b_out_data), b_out_ch, b_sat, b_e.d, b_e.ch, b_e.s, $time);
          end
        end
      end
      b_cherr_exp = 0;
      if (clr) begin
        b_exp.delete(); b_hist[0].delete(); b_hist[1].delete();
      end else if (b_in_valid && b_in_ready) begin
        b_hist[b_in_ch].push_front(longint'($signed(b_in_data)));
        if (b_hist[b_in_ch].size() > 12) void'(b_hist[b_in_ch].pop_back());
        b_exp.push_back(predict(b_hist[b_in_ch], int'(b_in_ch), B_GS, B_OW));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic a_put(input int ch, input int d);
    bit done = 0;
    a_in_valid = 1'b1; a_in_ch = ch[0]; a_in_data = d[10:0];
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = a_in_ready;
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    if (!done) begin
      checks++; errors++; $display("FAIL a_put_timeout got no handshake exp handshake");
    end
  endtask

  task automatic b_put(input int ch, input int d);
    bit done = 0;
    b_in_valid = 1'b1; b_in_ch = ch[0]; b_in_data = d[10:0];
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = b_in_ready;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    if (!done) begin
      checks++; errors++; $display("FAIL b_put_timeout got no handshake exp handshake");
    end
  endtask

  task automatic check_a_triangle(input string name);
    checks++;
    if (a_got.size() != 16) begin
      errors++; $display("FAIL %s_count got %0d exp 16", name, a_got.size());
    end
    for (int i = 0; i < 16 && i < a_got.size(); i++) begin
      checks++;
      if (a_got[i] != longint'(tri_ref[i])) begin
        errors++; $display("FAIL %s[%0d] got %0d exp %0d", name, i, a_got[i], tri_ref[i]);
      end
    end
  endtask

  task automatic a_impulse();
    a_got.delete();
    a_put(0, 1);
    repeat (15) a_put(0, 0);
    idle(3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_out_data, a_out_ch, a_sat, a_ch_err} !== '0) begin
      errors++; $display("FAIL reset_a got v%b d%0d ch%b s%b e%b exp all 0", a_out_valid, a_out_data, a_out_ch, a_sat, a_ch_err);
    end
    checks++;
    if ({b_out_valid, b_out_data, b_out_ch, b_sat, b_ch_err} !== '0) begin
      errors++; $display("FAIL reset_b got v%b d%0d ch%b s%b e%b exp all 0", b_out_valid, b_out_data, b_out_ch, b_sat, b_ch_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b%b exp 11", a_in_ready, b_in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    do_reset();
    a_impulse();
    check_a_triangle("impulse");
  endtask

  task automatic test_constant();
    do_reset();
    a_got.delete();
    repeat (16) a_put(0, 100);
    idle(3);
    checks++;
    if (a_got.size() != 16 || a_got[0] != 100 || a_got[10] != 3600 || a_got[15] != 3600) begin
      errors++;
      $display("FAIL constant got n%0d first %0d 11th %0d last %0d exp n16 100 3600 3600",
               a_got.size(), a_got[0], a_got[10], a_got[15]);
    end
  endtask

  task automatic test_multichannel();
    do_reset();
    b_got.delete(); b_got_ch.delete(); b_got_s.delete();
    for (int i = 0; i < 24; i++) b_put(i % 2, (i == 1) ? 2 : 0);
    idle(3);
    checks++;
    if (b_got.size() != 24) begin
      errors++; $display("FAIL multich_count got %0d exp 24", b_got.size());
    end
    for (int i = 0; i < 24 && i < b_got.size(); i++) begin
      checks++;
      if (b_got_ch[i] != i % 2 || b_got[i] != ((i % 2 == 1) ? longint'(tri_ref[i / 2]) : 0)) begin
        errors++;
        $display("FAIL multich[%0d] got ch%0d %0d exp ch%0d %0d", i, b_got_ch[i], b_got[i],
                 i % 2, (i % 2 == 1) ? tri_ref[i / 2] : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    int vals[20];
    logic [A_OW-1:0] held;
    do_reset();
    a_got.delete();
    for (int i = 0; i < 20; i++) vals[i] = int'($urandom_range(0, 2047)) - 1024;
    fork
      for (int i = 0; i < 20; i++) a_put(0, vals[i]);
      begin
        idle(6);
        a_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (c == 0) held = a_out_data;
          checks++;
          if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== held) begin
            errors++;
            $display("FAIL backpressure c%0d got rdy%b v%b d%0d exp rdy0 v1 d%0d", c, a_in_ready, a_out_valid, a_out_data, held);
          end
          @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
      end
    join
    idle(3);
    checks++;
    if (a_got.size() != 20 || a_exp.size() != 0) begin
      errors++; $display("FAIL backpressure_count got %0d pending %0d exp 20 pending 0", a_got.size(), a_exp.size());
    end
  endtask

  task automatic test_saturation();
    longint exp_last;
    bit     exp_s;
    do_reset();
    b_got.delete(); b_got_ch.delete(); b_got_s.delete();
    repeat (16) b_put(0, 1023);
    idle(3);
`ifdef PT_LPF_SAT_EN
    exp_last = 2047; exp_s = 1;
`else
    exp_last = 2030; exp_s = 0;
`endif
    checks++;
    if (b_got.size() != 16 || b_got[15] != exp_last || b_got_s[15] != exp_s || b_got[0] != 511) begin
      errors++;
      $display("FAIL saturation got n%0d first %0d last %0d s%b exp n16 511 %0d s%b",
               b_got.size(), b_got[0], b_got[15], b_got_s[15], exp_last, exp_s);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    a_put(0, 1);
    repeat (3) a_put(0, 0);
    a_out_ready = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drop got %b exp 0", a_out_valid);
    end
    @(posedge clk); #1;
    a_impulse();
    check_a_triangle("rst_mid");
  endtask

  task automatic test_clr_mid();
    do_reset();
    a_put(0, 1);
    repeat (4) a_put(0, 0);
    clr = 1'b1; a_in_valid = 1'b1; a_in_ch = 1'b0; a_in_data = 11'd50;
    @(posedge clk); #1;
    clr = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL clr_mid_drop got %b exp 0", a_out_valid);
    end
    @(posedge clk); #1;
    a_impulse();
    check_a_triangle("clr_mid");
  endtask

  task automatic test_ch_err();
    do_reset();
    a_put(1, 77);
    @(negedge clk);
    checks++;
    if (a_ch_err !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL ch_err_pulse got e%b v%b exp e1 v0", a_ch_err, a_out_valid);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (a_ch_err !== 1'b0) begin
      errors++; $display("FAIL ch_err_clear got %b exp 0", a_ch_err);
    end
    @(posedge clk); #1;
    a_impulse();
    check_a_triangle("ch_err_hist");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_ch     = ($urandom_range(0, 9) == 0);
      a_in_data   = 11'($urandom_range(0, 2047));
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_ch     = 1'($urandom_range(0, 1));
      b_in_data   = 11'($urandom_range(0, 2047));
      b_out_ready = ($urandom_range(0, 3) != 0);
      clr         = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    clr = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    idle(3);
    checks++;
    if (a_exp.size() != 0 || b_exp.size() != 0) begin
      errors++; $display("FAIL random_drain got pending %0d/%0d exp 0/0", a_exp.size(), b_exp.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_impulse();
    test_constant();
    test_multichannel();
    test_backpressure();
    test_saturation();
    test_rst_mid();
    test_clr_mid();
    test_ch_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pt_lowpass_filter.md
PT_LOWPASS_FILTER -- requirements
Module: pt_lowpass_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 11: signed input sample width.
REQ-002 Parameter DELAY, default 6: comb delay D, range 2..32.
REQ-003 Parameter NUM_CH, default 1: interleaved channel count, range 1..16.
REQ-004 Parameter GAIN_SHIFT, default 0: arithmetic right shift applied to the output, range 0..2*clog2(DELAY).
REQ-005 Parameter OUT_WIDTH, default DATA_WIDTH+2*clog2(DELAY): signed output width.
REQ-006 Port clk, input, 1: the only clock; all logic on its rising edge.
REQ-007 Port rst, input, 1: synchronous reset, active-high.
REQ-008 Port clr, input, 1: synchronous history flush for all channels.
REQ-009 Port in_valid, input, 1: an input sample is offered.
REQ-010 Port in_ready, output, 1: the block can accept a sample.
REQ-011 Port in_ch, input, max(1,clog2(NUM_CH)): channel of the offered sample.
REQ-012 Port in_data, input, DATA_WIDTH: signed sample x[n].
REQ-013 Port out_valid, output, 1: out_data, out_ch and sat_flag are valid.
REQ-014 Port out_ready, input, 1: the consumer accepts the output.
REQ-015 Port out_ch, output, max(1,clog2(NUM_CH)): channel of out_data.
REQ-016 Port out_data, output, OUT_WIDTH: signed filtered sample.
REQ-017 Port sat_flag, output, 1: out_data was clamped.
REQ-018 Port ch_err, output, 1: one-cycle pulse when a sample with in_ch>=NUM_CH is accepted.

Function
REQ-019 Per channel, y[n] SHALL equal 2*y[n-1] - y[n-2] + x[n] - 2*x[n-D] + x[n-2D], computed exactly; out_data SHALL equal y[n]>>>GAIN_SHIFT, reduced to OUT_WIDTH.
REQ-020 Internal accumulator width SHALL be DATA_WIDTH+2*clog2(DELAY)+2, so the recursion never overflows for any input sequence.
REQ-021 Each channel SHALL keep an independent 2*D-deep x history and a 2-deep y history; a channel's history SHALL advance only when a sample of that channel is accepted.
REQ-022 A sample is accepted when in_valid && in_ready; out_valid SHALL rise on the next cycle (latency 1).
REQ-023 in_ready SHALL equal !out_valid || out_ready, giving full throughput of one sample per cycle under no backpressure.
REQ-024 out_valid, out_data, out_ch and sat_flag SHALL be held stable while out_valid && !out_ready.
REQ-025 An accepted sample with in_ch>=NUM_CH SHALL pulse ch_err, SHALL produce no output and SHALL not modify any history.
REQ-026 clr SHALL zero all histories and drop any pending output; when clr and an input handshake occur in the same cycle, clr SHALL win and the sample SHALL be discarded.

Reset
REQ-027 While rst is high, all histories, out_data, out_ch, sat_flag, ch_err and out_valid SHALL be 0; in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-028 rst asserted mid-stream SHALL discard any pending output with no partial update.

Configuration
REQ-029 With PT_LPF_SAT_EN defined, the shifted result SHALL clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and sat_flag SHALL be set on a clamp.
REQ-030 Without PT_LPF_SAT_EN, the shifted result SHALL wrap by keeping the low OUT_WIDTH bits, and sat_flag SHALL be constant 0.

Structure
REQ-031 Package pt_pkg SHALL hold the accumulator-width function and the shared clog2 helper for all Pan-Tompkins stages.
REQ-032 Sub-module pt_hist_ram SHALL hold the per-channel x and y histories, indexed by channel with a per-channel write pointer; the top level SHALL hold the arithmetic and the handshake.

Verification
REQ-033 Defaults, impulse of 1 then zeros on ch0 -> out_data sequence 1,2,3,4,5,6,5,4,3,2,1 then 0 forever.
REQ-034 Defaults, constant 100 on ch0 -> output ramps up and reaches 3600 at the 11th sample, then holds at 3600.
REQ-035 NUM_CH=2, impulse on ch1 interleaved with zeros on ch0 -> ch1 produces the triangle from REQ-033, ch0 stays 0, and out_ch alternates.
REQ-036 out_ready held low for 3 cycles mid-stream -> in_ready is low, out_data is stable, and no samples are lost or duplicated.
REQ-037 OUT_WIDTH=12, constant 1023 -> with PT_LPF_SAT_EN, output clamps to 2047 with sat_flag=1; without it, output equals the low 12 bits of the exact value.
REQ-038 rst or clr asserted mid-impulse-response -> next impulse reproduces the exact REQ-033 triangle; in_ch=NUM_CH -> ch_err pulses and there is no output.
